// File: rtl/mult_seq_pkg.sv
// Shared definitions for the limb-sequenced multiplier: FSM state encoding and default limb width.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LIMB_W_DEF = 8;

endpackage

// File: rtl/array_multiplier.sv
// Existing 8x8 unsigned combinational multiplier core, shared by every limb pass.
module array_multiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] m
);

  assign m = a * b;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle OP_W x OP_W multiplier built from one shared 8x8 core, one limb product per clock.
// Optional macro MULT_SIGNED_EN selects two's-complement operands and product (sign-magnitude around the core).
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int  LIMB_W = LIMB_W_DEF,
  parameter int  NLIMB  = 2,
  localparam int OP_W   = LIMB_W * NLIMB
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OP_W-1:0] p,
  output logic              busy
);

  localparam int P_W   = 2 * OP_W;
  localparam int NPASS = NLIMB * NLIMB;
  localparam int IDX_W = $clog2(NPASS + 1);

  state_t state, state_next;

  logic [OP_W-1:0]     a_lat, b_lat, a_mag, b_mag;
  logic [P_W-1:0]      acc, term, acc_sum, result;
  logic [IDX_W-1:0]    idx, i_sel, j_sel;
  logic [LIMB_W-1:0]   core_a, core_b;
  logic [2*LIMB_W-1:0] core_m;
  logic                accept, last;

  assign accept = in_valid && in_ready;
  assign last   = (idx == IDX_W'(NPASS - 1));

  // idx walks the limb pairs row-major: i picks the a limb, j the b limb.
  assign i_sel   = idx / IDX_W'(NLIMB);
  assign j_sel   = idx % IDX_W'(NLIMB);
  assign core_a  = a_lat[i_sel*LIMB_W +: LIMB_W];
  assign core_b  = b_lat[j_sel*LIMB_W +: LIMB_W];
  assign term    = P_W'(core_m) << (LIMB_W * (i_sel + j_sel));
  assign acc_sum = acc + term;

  array_multiplier u_core (
    .a(core_a),
    .b(core_b),
    .m(core_m)
  );

`ifdef MULT_SIGNED_EN
  logic neg;

  // Magnitudes fit OP_W unsigned bits, including the most negative operand.
  assign a_mag  = a[OP_W-1] ? -a : a;
  assign b_mag  = b[OP_W-1] ? -b : b;
  assign result = neg ? -acc_sum : acc_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg <= 1'b0;
    end else if (state == IDLE && accept) begin
      neg <= a[OP_W-1] ^ b[OP_W-1];
    end
  end
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign result = acc_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = MUL;
      end
      MUL: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // p only changes when a full product is ready, so a stalled DONE holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_lat <= '0;
      b_lat <= '0;
      acc   <= '0;
      idx   <= '0;
      p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_lat <= a_mag;
            b_lat <= b_mag;
            acc   <= '0;
            idx   <= '0;
          end
        end
        MUL: begin
          acc <= acc_sum;
          idx <= idx + IDX_W'(1);
          if (last) p <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: spec vector table, hand-written handshake/reset cases, random ops vs arithmetic model.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] p;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[$];

  mult_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
`ifdef MULT_SIGNED_EN
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    return 32'(sx * sy);
`else
    longint ux = longint'(x);
    longint uy = longint'(y);
    return 32'(ux * uy);
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, measure latency, optionally stall the consumer, then hand off.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input int stall,
                               input logic [31:0] exp, input string name);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      step();
      cyc++;
    end
    in_valid = 1'b1;
    a = av;
    b = bv;
    step();
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    checkOutput({name, " busy after accept"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    checkOutput({name, " latency"}, 32'(cyc), 32'd4);
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      checkOutput({name, " held p"}, p, exp);
      checkOutput({name, " in_ready while held"}, 32'(in_ready), 32'd0);
      in_valid = 1'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      step();
    end
    in_valid = 1'b0;
    checkOutput({name, " p"}, p, exp);
    checkOutput({name, " out_valid"}, 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({name, " in_ready after handshake"}, 32'(in_ready), 32'd1);
    checkOutput({name, " out_valid after handshake"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    logic [15:0] ra, rb;

`ifdef MULT_SIGNED_EN
    vecs.push_back('{16'd5,    16'd5,    32'd25});
    vecs.push_back('{16'hFFFB, 16'h0003, 32'hFFFFFFF1});
    vecs.push_back('{16'h8000, 16'h8000, 32'h40000000});
    vecs.push_back('{16'h8000, 16'h0001, 32'hFFFF8000});
    vecs.push_back('{16'h0000, 16'hBEEF, 32'h0});
`else
    vecs.push_back('{16'd5,    16'd5,    32'd25});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 32'hFFFE0001});
    vecs.push_back('{16'h0000, 16'hBEEF, 32'h0});
    vecs.push_back('{16'h00FF, 16'h0101, 32'h0000FFFF});
`endif

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset p", p, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].a, vecs[k].b, 0, vecs[k].p, $sformatf("vec%0d", k));
    end

    applyStimulus(16'h1234, 16'h0010, 3, 32'h00012340, "backpressure");
    applyStimulus(16'd9, 16'd9, 0, 32'd81, "after backpressure");

    // Reset asserted during the second MUL cycle.
    in_valid = 1'b1;
    a = 16'h00FF;
    b = 16'h0101;
    step();
    in_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset in_ready", 32'(in_ready), 32'd1);
    checkOutput("midreset p", p, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    applyStimulus(16'h00FF, 16'h0101, 0, 32'h0000FFFF, "post reset");

    // Back-to-back with in_valid held; operands change while busy and must be ignored.
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 16'd3;
    b = 16'd7;
    step();
    a = 16'd100;
    b = 16'd200;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    checkOutput("b2b first latency", 32'(cyc), 32'd4);
    checkOutput("b2b first p", p, 32'd21);
    step();
    checkOutput("b2b in_ready after handshake", 32'(in_ready), 32'd1);
    checkOutput("b2b busy after handshake", 32'(busy), 32'd0);
    step();
    checkOutput("b2b second accept", 32'(busy), 32'd1);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    checkOutput("b2b second latency", 32'(cyc), 32'd4);
    checkOutput("b2b second p", p, 32'd20000);
    step();
    out_ready = 1'b0;

    for (int n = 0; n < 150; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 10 == 0) ra = 16'h8000;
      if (n % 10 == 5) rb = 16'hFFFF;
      applyStimulus(ra, rb, int'($urandom_range(0, 3)), model(ra, rb), $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
